// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, op and priority encodings for the memory line arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2, ERR = 2'd3} state_e;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
  localparam int PRIO_RR = 0;
  localparam int PRIO_FIXED = 1;
  // channel examined at search position i; fixed mode ignores the pointer
  function automatic int slot(input int ptr, input int i, input int n, input logic fixed);
    return fixed ? i : (ptr + i) % n;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational masked-priority selector, rotating from ptr or fixed lowest-index-first
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     idx
);
  // walk from lowest to highest priority so the highest-priority requester is written last
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[IW'(slot(int'(ptr), i, NUM_CH, mode))]) begin
        gnt = NUM_CH'(1) << slot(int'(ptr), i, NUM_CH, mode);
        idx = IW'(slot(int'(ptr), i, NUM_CH, mode));
      end
    end
  end
endmodule

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: N-channel cache line read/write arbiter onto one memory port with watchdog
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int PRIO_MODE   = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_rd,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*LINE_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        rsp_ready,
  output logic [NUM_CH-1:0]        rsp_err,
  output logic [LINE_W-1:0]        rsp_rdata,
  output logic [NUM_CH-1:0]        grant,
  output logic                     mem_oe,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_ready
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  state_e state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d, req_any, win;
  logic [IW-1:0] ptr_q, ptr_d, win_idx;
  logic op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  assign req_any = req_rd | req_wr;
  rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
    .req  (req_any),
    .ptr  (ptr_q),
    .mode (PRIO_MODE == PRIO_FIXED),
    .gnt  (win),
    .idx  (win_idx)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    case (state_q)
      IDLE: if (|req_any) begin
        state_d = BUSY;
        grant_d = win;
        op_d    = req_wr[win_idx] ? OP_WR : OP_RD;
        addr_d  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        wdata_d = req_wdata[int'(win_idx)*LINE_W +: LINE_W];
        cnt_d   = '0;
        ptr_d   = (win_idx == IW'(NUM_CH - 1)) ? '0 : win_idx + IW'(1);
      end
      BUSY: if (mem_ready) begin
        rdata_d = mem_rdata;
        state_d = RESP;
      end else begin
        cnt_d = cnt_inc;
        if (TIMEOUT_CYC != 0 && cnt_inc == CW'(TIMEOUT_CYC)) state_d = ERR;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end
  assign grant     = grant_q;
  assign mem_oe    = (state_q == BUSY) && (op_q == OP_RD);
  assign mem_we    = (state_q == BUSY) && (op_q == OP_WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_ready = (state_q == RESP) ? grant_q : '0;
  assign rsp_err   = (state_q == ERR) ? grant_q : '0;
endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter: directed checks on a 2-ch RR (timeout 4), a 4-ch RR and a 2-ch fixed-priority arbiter
module tb_mem_line_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam logic [LW-1:0] LINE1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [LW-1:0] DEAD = {4{32'hDEADBEEF}};
  logic clk = 1'b0;
  logic reset = 1'b1;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [1:0] a_rd, a_wr, a_rdy, a_err, a_gnt;
  logic [2*AW-1:0] a_addr;
  logic [2*LW-1:0] a_wdata;
  logic [LW-1:0] a_rdata, a_mwdata, a_mrdata;
  logic [AW-1:0] a_maddr;
  logic a_oe, a_we, a_mready;
  logic [3:0] b_rd, b_wr, b_rdy, b_err, b_gnt;
  logic [4*AW-1:0] b_addr;
  logic [4*LW-1:0] b_wdata;
  logic [LW-1:0] b_rdata, b_mwdata;
  logic [AW-1:0] b_maddr;
  logic b_oe, b_we;
  logic [1:0] c_rd, c_wr, c_rdy, c_err, c_gnt;
  logic [2*AW-1:0] c_addr;
  logic [2*LW-1:0] c_wdata;
  logic [LW-1:0] c_rdata, c_mwdata;
  logic [AW-1:0] c_maddr;
  logic c_oe, c_we;

  always #5 clk = ~clk;

  mem_line_arbiter #(.NUM_CH(2), .PRIO_MODE(0), .TIMEOUT_CYC(4)) dut_a (
    .clk(clk), .reset(reset), .req_rd(a_rd), .req_wr(a_wr), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_ready(a_rdy), .rsp_err(a_err), .rsp_rdata(a_rdata), .grant(a_gnt), .mem_oe(a_oe), .mem_we(a_we),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(a_mrdata), .mem_ready(a_mready));
  mem_line_arbiter #(.NUM_CH(4), .PRIO_MODE(0)) dut_b (
    .clk(clk), .reset(reset), .req_rd(b_rd), .req_wr(b_wr), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_ready(b_rdy), .rsp_err(b_err), .rsp_rdata(b_rdata), .grant(b_gnt), .mem_oe(b_oe), .mem_we(b_we),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(LINE1), .mem_ready(1'b1));
  mem_line_arbiter #(.NUM_CH(2), .PRIO_MODE(1)) dut_c (
    .clk(clk), .reset(reset), .req_rd(c_rd), .req_wr(c_wr), .req_addr(c_addr), .req_wdata(c_wdata),
    .rsp_ready(c_rdy), .rsp_err(c_err), .rsp_rdata(c_rdata), .grant(c_gnt), .mem_oe(c_oe), .mem_we(c_we),
    .mem_addr(c_maddr), .mem_wdata(c_mwdata), .mem_rdata(LINE1), .mem_ready(1'b1));

  function automatic int oh_idx(input logic [7:0] v);
    int r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    total_cnt++;
    if ({a_gnt, a_oe, a_we, a_rdy, a_err} !== 8'h00) $display("FAIL reset_ctrl got %h want 00", {a_gnt, a_oe, a_we, a_rdy, a_err});
    else pass_cnt++;
    total_cnt++;
    if ({a_maddr, a_mwdata, a_rdata} !== '0) $display("FAIL reset_data got nonzero want 0");
    else pass_cnt++;
    total_cnt++;
    if ({b_gnt, b_rdy, b_err, b_oe, b_we, c_gnt, c_rdy, c_err, c_oe, c_we} !== '0) $display("FAIL reset_bc got nonzero want 0");
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int n = 0, oe_n = 0, addr_bad = 0;
    a_addr[AW +: AW] = 32'h40;
    a_rd = 2'b10;
    a_mready = 1'b0;
    while (a_rdy == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
      if (a_oe) begin
        oe_n++;
        if (a_maddr !== 32'h40) addr_bad++;
      end
      a_mready = (oe_n >= 3);
    end
    total_cnt++;
    if (oe_n != 3) $display("FAIL rd_oe_cycles got %0d want 3", oe_n); else pass_cnt++;
    total_cnt++;
    if (addr_bad != 0) $display("FAIL rd_addr got %0d bad cycles want 0", addr_bad); else pass_cnt++;
    total_cnt++;
    if (a_rdy !== 2'b10) $display("FAIL rd_ready got %b want 10", a_rdy); else pass_cnt++;
    total_cnt++;
    if (a_rdata !== LINE1) $display("FAIL rd_data got %h want %h", a_rdata, LINE1); else pass_cnt++;
    total_cnt++;
    if (n + 1 != 5) $display("FAIL rd_latency got %0d want 5", n + 1); else pass_cnt++;
    a_rd = 2'b00;
    a_mready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({a_rdy, a_gnt} !== 4'b0000) $display("FAIL rd_pulse_end got %b want 0000", {a_rdy, a_gnt}); else pass_cnt++;
  endtask

  task automatic test_rr_two();
    int got[4] = '{-1, -1, -1, -1};
    int n = 0, cyc = 0;
    a_mready = 1'b1;
    a_rd = 2'b11;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (a_rdy != 2'b00) begin
        got[n] = oh_idx(8'(a_rdy));
        n++;
        if (n == 4) a_rd = 2'b00;
      end
    end
    a_rd = 2'b00;
    a_mready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (got[i] != i % 2) $display("FAIL rr2_grant%0d got %0d want %0d", i, got[i], i % 2); else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_fixed();
    int got[4] = '{-1, -1, -1, -1};
    int want[4] = '{0, 0, 0, 1};
    int n = 0, cyc = 0;
    c_rd = 2'b11;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (c_rdy != 2'b00) begin
        got[n] = oh_idx(8'(c_rdy));
        n++;
        if (n == 3) c_rd = 2'b10;
        if (n == 4) c_rd = 2'b00;
      end
    end
    c_rd = 2'b00;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (got[i] != want[i]) $display("FAIL fixed_grant%0d got %0d want %0d", i, got[i], want[i]); else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int got[9] = '{default: -1};
    int n = 0, cyc = 0;
    b_rd = 4'hF;
    while (n < 9 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (b_rdy != 4'h0) begin
        got[n] = oh_idx(8'(b_rdy));
        if (b_gnt !== b_rdy) got[n] = -2;
        n++;
        if (n == 8) b_rd = 4'b1000;
        if (n == 9) b_rd = 4'h0;
      end
    end
    b_rd = 4'h0;
    for (int i = 0; i < 9; i++) begin
      total_cnt++;
      if (got[i] != (i < 8 ? i % 4 : 3)) $display("FAIL wrap_grant%0d got %0d want %0d", i, got[i], i < 8 ? i % 4 : 3);
      else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_write_drop();
    a_addr[0 +: AW] = 32'h100;
    a_wdata[0 +: LW] = DEAD;
    a_wr = 2'b01;
    a_rd = 2'b01;
    a_mready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({a_we, a_oe, a_gnt} !== 4'b1001) $display("FAIL wr_start got %b want 1001", {a_we, a_oe, a_gnt}); else pass_cnt++;
    a_wr = 2'b00;
    a_rd = 2'b00;
    a_addr = '1;
    a_wdata = '0;
    @(negedge clk);
    total_cnt++;
    if (a_we !== 1'b1 || a_maddr !== 32'h100) $display("FAIL wr_hold got we=%b addr=%h want we=1 addr=00000100", a_we, a_maddr);
    else pass_cnt++;
    total_cnt++;
    if (a_mwdata !== DEAD) $display("FAIL wr_wdata got %h want %h", a_mwdata, DEAD); else pass_cnt++;
    a_mready = 1'b1;
    @(negedge clk);
    a_mready = 1'b0;
    total_cnt++;
    if ({a_rdy, a_we} !== 3'b010) $display("FAIL wr_resp got %b want 010", {a_rdy, a_we}); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n = 0, busy = 0;
    a_addr = '0;
    a_mready = 1'b0;
    a_rd = 2'b11;
    while (a_err == 2'b00 && a_rdy == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
      if (a_oe) busy++;
    end
    total_cnt++;
    if (busy != 4) $display("FAIL to_busy_cycles got %0d want 4", busy); else pass_cnt++;
    total_cnt++;
    if ({a_err, a_rdy, a_oe} !== 5'b10000) $display("FAIL to_err got %b want 10000", {a_err, a_rdy, a_oe}); else pass_cnt++;
    total_cnt++;
    if (a_rdata !== LINE1) $display("FAIL to_rdata got %h want %h", a_rdata, LINE1); else pass_cnt++;
    a_rd = 2'b01;
    a_mready = 1'b1;
    n = 0;
    while (a_rdy == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (a_rdy !== 2'b01) $display("FAIL to_next got %b want 01", a_rdy); else pass_cnt++;
    a_rd = 2'b00;
    a_mready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    int stray = 0, n = 0;
    a_rd = 2'b01;
    a_mready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({a_oe, a_gnt} !== 3'b101) $display("FAIL rst_busy got %b want 101", {a_oe, a_gnt}); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({a_gnt, a_oe, a_we, a_rdy, a_err} !== 8'h00) $display("FAIL rst_async got %h want 00", {a_gnt, a_oe, a_we, a_rdy, a_err});
    else pass_cnt++;
    total_cnt++;
    if ({a_maddr, a_rdata} !== '0) $display("FAIL rst_async_data got nonzero want 0"); else pass_cnt++;
    a_rd = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (a_rdy != 2'b00 || a_err != 2'b00) stray++;
    end
    total_cnt++;
    if (stray != 0) $display("FAIL rst_no_pulse got %0d pulses want 0", stray); else pass_cnt++;
    a_rd = 2'b11;
    a_mready = 1'b1;
    while (a_rdy == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (a_rdy !== 2'b01) $display("FAIL rst_ptr got %b want 01", a_rdy); else pass_cnt++;
    a_rd = 2'b00;
    a_mready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    a_rd = '0; a_wr = '0; a_addr = '0; a_wdata = '0; a_mrdata = LINE1; a_mready = 1'b0;
    b_rd = '0; b_wr = '0; b_addr = '0; b_wdata = '0;
    c_rd = '0; c_wr = '0; c_addr = '0; c_wdata = '0;
    test_reset();
    test_single_read();
    test_rr_two();
    test_fixed();
    test_wrap();
    test_write_drop();
    test_timeout();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
